pipeline_hazard_ctrl: RTL
=========================

// Module: pipeline_hazard_ctrl
// PURPOSE
// - Drives the load enables and bubble/flush selects of the PC and of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers.
// - Resolves four conditions: data-memory stalls, taken-branch flushes, load-use hazards and instruction-memory misses.
// - Sequential parts: a reset-fill phase, a data-memory wait FSM and optional performance counters.
// PARAMETERS
// - INIT_CYCLES  default 2   number of cycles after reset that every pipeline register is loaded with a bubble
// - CNT_W        default 16  width of each performance counter (only used with PERF_CNT_EN)
// PORTS
// - clk           in   1  clock, all state updates on the rising edge
// - reset_n       in   1  synchronous, active-low reset
// - id_sr1_num    in   3  SR1 register number of the instruction in ID
// - id_sr2_num    in   3  SR2 register number of the instruction in ID
// - id_uses_sr1   in   1  instruction in ID reads SR1
// - id_uses_sr2   in   1  instruction in ID reads SR2
// - ex_dest       in   3  destination register of the instruction in EX
// - ex_is_load    in   1  instruction in EX is a memory load that writes a register (LDR/LDB/LDI)
// - mem_br_taken  in   1  instruction in MEM redirects the PC (taken BR, JMP, JSR, TRAP)
// - imem_resp     in   1  instruction memory returns a valid word this cycle
// - dmem_req      in   1  instruction in MEM accesses data memory
// - dmem_resp     in   1  data memory completes this cycle
// - load_pc       out  1  PC register load enable
// - load_if_id    out  1  IF/ID load enable
// - load_id_ex    out  1  ID/EX load enable
// - load_ex_mem   out  1  EX/MEM load enable
// - load_mem_wb   out  1  MEM/WB load enable
// - bubble_if_id  out  1  IF/ID captures a zero control word instead of its data input
// - bubble_id_ex  out  1  ID/EX captures a zero control word and dest 3'b000
// - bubble_ex_mem out  1  EX/MEM captures a zero control word
// - stall_cnt     out  CNT_W  count of frozen cycles (PERF_CNT_EN only)
// - flush_cnt     out  CNT_W  count of taken-branch flushes (PERF_CNT_EN only)
// BEHAVIOUR
// - FSM states and transitions:
//   - INIT -> RUN after INIT_CYCLES cycles.
//   - RUN -> MEM_WAIT when dmem_req & !dmem_resp.
//   - MEM_WAIT -> RUN on dmem_resp.
// - Reset (reset_n=0 at an edge):
//   - State goes to INIT and the init counter is cleared; the counters clear to 0.
//   - Reset applied mid-MEM_WAIT discards the outstanding wait.
// - INIT outputs: all load_* = 1 and all bubble_* = 1.
// - Outputs are combinational from state and inputs (0-cycle latency).
// - Priority in RUN, highest first:
//   1. dmem freeze (dmem_req & !dmem_resp): all load_* = 0, all bubble_* = 0.
//   2. mem_br_taken: all load_* = 1; bubble_if_id = bubble_id_ex = bubble_ex_mem = 1.
//   3. Load-use hazard, where hazard = ex_is_load & ((id_uses_sr1 & id_sr1_num==ex_dest) | (id_uses_sr2 & id_sr2_num==ex_dest)):
//      - load_pc = load_if_id = 0.
//      - load_id_ex = 1 with bubble_id_ex = 1.
//      - load_ex_mem = load_mem_wb = 1.
//   4. !imem_resp: load_pc = 0; load_if_id = 1 with bubble_if_id = 1; downstream loads = 1.
//   5. Otherwise: all load_* = 1 and all bubble_* = 0.
// - MEM_WAIT:
//   - While !dmem_resp: identical to freeze.
//   - On the cycle dmem_resp = 1: evaluate priorities 2-5 as in RUN.
// - Frozen registers keep their contents, so a branch or hazard pending during a freeze is re-evaluated when the freeze ends; nothing is lost.
// - Load-use inserts exactly one bubble; the hazard then clears because EX holds a bubble.
// - A load-use hazard and a branch in the same cycle resolve as a flush; the hazard instruction is squashed.
// - A branch in the same cycle as an imem miss: the flush wins and the PC loads the target.
// CONFIGURATION
// - PERF_CNT_EN defined:
//   - stall_cnt increments on every cycle with all load_* = 0, outside INIT.
//   - flush_cnt increments on every priority-2 cycle.
//   - Both counters saturate at all-ones and clear on reset.
// - PERF_CNT_EN undefined: no counters; stall_cnt and flush_cnt are tied to 0.
// TESTING
// - Reset low 1 cycle, INIT_CYCLES=2 -> 2 cycles of all load=1 and all bubble=1, then RUN with all bubble=0.
// - ex_is_load=1, ex_dest=3, id_uses_sr1=1, id_sr1_num=3 -> load_pc=0, load_if_id=0, bubble_id_ex=1 for exactly 1 cycle.
// - dmem_req=1 and dmem_resp held low for 4 cycles -> all load=0 for 4 cycles; on resp all load=1; stall_cnt=4.
// - mem_br_taken=1 together with a load-use hazard -> all load=1, 3 bubbles, flush_cnt +1.
// - dmem freeze together with mem_br_taken=1 -> freeze first; the flush occurs on the cycle dmem_resp=1.
// - Reset asserted during MEM_WAIT -> next state INIT; counters=0; no stale freeze after INIT.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: PC and pipeline-register load enables and bubble selects.
// Optional PERF_CNT_EN macro adds saturating stall/flush counters.
module pipeline_hazard_ctrl #(
    parameter int unsigned INIT_CYCLES = 2,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       id_sr1_num,
    input  logic [2:0]       id_sr2_num,
    input  logic             id_uses_sr1,
    input  logic             id_uses_sr2,
    input  logic [2:0]       ex_dest,
    input  logic             ex_is_load,
    input  logic             mem_br_taken,
    input  logic             imem_resp,
    input  logic             dmem_req,
    input  logic             dmem_resp,
    output logic             load_pc,
    output logic             load_if_id,
    output logic             load_id_ex,
    output logic             load_ex_mem,
    output logic             load_mem_wb,
    output logic             bubble_if_id,
    output logic             bubble_id_ex,
    output logic             bubble_ex_mem,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int unsigned INIT_W = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;

    typedef enum logic [1:0] {
        ST_INIT     = 2'd0,
        ST_RUN      = 2'd1,
        ST_MEM_WAIT = 2'd2
    } state_t;

    state_t            state;
    logic [INIT_W-1:0] init_cnt;
    logic              init_done_c;
    logic              run_c;
    logic              freeze_c;
    logic              hazard_c;

    assign init_done_c = (INIT_CYCLES <= 1) || (init_cnt == INIT_W'(INIT_CYCLES - 1));
    assign run_c       = (state != ST_INIT);

    // Once waiting on data memory, only the response releases the freeze.
    assign freeze_c = (state == ST_MEM_WAIT) ? !dmem_resp : (dmem_req & !dmem_resp);

    assign hazard_c = ex_is_load &
                      ((id_uses_sr1 & (id_sr1_num == ex_dest)) |
                       (id_uses_sr2 & (id_sr2_num == ex_dest)));

    // State register with next-state logic; reset discards any outstanding wait.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state    <= ST_INIT;
            init_cnt <= '0;
        end else begin
            case (state)
                ST_INIT: begin
                    if (init_done_c) begin
                        state <= ST_RUN;
                    end else begin
                        init_cnt <= init_cnt + INIT_W'(1);
                    end
                end
                ST_RUN: begin
                    if (freeze_c) begin
                        state <= ST_MEM_WAIT;
                    end
                end
                ST_MEM_WAIT: begin
                    if (dmem_resp) begin
                        state <= ST_RUN;
                    end
                end
                default: state <= ST_INIT;
            endcase
        end
    end

    // Load/bubble decode in priority order: freeze, flush, load-use, imem miss.
    always_comb begin
        load_pc       = 1'b1;
        load_if_id    = 1'b1;
        load_id_ex    = 1'b1;
        load_ex_mem   = 1'b1;
        load_mem_wb   = 1'b1;
        bubble_if_id  = 1'b0;
        bubble_id_ex  = 1'b0;
        bubble_ex_mem = 1'b0;
        if (!run_c) begin
            bubble_if_id  = 1'b1;
            bubble_id_ex  = 1'b1;
            bubble_ex_mem = 1'b1;
        end else if (freeze_c) begin
            load_pc     = 1'b0;
            load_if_id  = 1'b0;
            load_id_ex  = 1'b0;
            load_ex_mem = 1'b0;
            load_mem_wb = 1'b0;
        end else if (mem_br_taken) begin
            bubble_if_id  = 1'b1;
            bubble_id_ex  = 1'b1;
            bubble_ex_mem = 1'b1;
        end else if (hazard_c) begin
            load_pc      = 1'b0;
            load_if_id   = 1'b0;
            bubble_id_ex = 1'b1;
        end else if (!imem_resp) begin
            load_pc      = 1'b0;
            bubble_if_id = 1'b1;
        end
    end

`ifdef PERF_CNT_EN
    logic [CNT_W-1:0] stall_q;
    logic [CNT_W-1:0] flush_q;
    logic             flush_c;

    assign flush_c = run_c & !freeze_c & mem_br_taken;

    // Saturating event counters.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (run_c && freeze_c && (stall_q != '1)) begin
                stall_q <= stall_q + CNT_W'(1);
            end
            if (flush_c && (flush_q != '1)) begin
                flush_q <= flush_q + CNT_W'(1);
            end
        end
    end

    assign stall_cnt = stall_q;
    assign flush_cnt = flush_q;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule
